conv_result_writer: RTL and testbench
=====================================

CONV_RESULT_WRITER -- requirements
Module: conv_result_writer

Interface
REQ-001 Parameter DATA_W, 20, signed width of the multiply-adder result beat.
REQ-002 Parameter BIAS_W, 8, signed bias width.
REQ-003 Parameter FRAC, 4, arithmetic right shift applied after bias add.
REQ-004 Parameter NUM_CH, 6, output channels per layer.
REQ-005 Parameter PIX, 576, result beats per channel.
REQ-006 Parameter ADDR_W, 15, result RAM address width.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_n  in  1  synchronous active-high reset; the _n suffix is kept for port-name consistency, not polarity.
REQ-010 start  in  1  one-cycle request to begin collecting a layer.
REQ-011 in_data  in  DATA_W  signed multiply-adder result.
REQ-012 in_valid, in_start, in_end  in  1 each  beat qualifier, first-beat-of-channel flag, last-beat-of-channel flag.
REQ-013 bias_rd_en  out  1  bias ROM enable; bias_addr  out  7  channel index; bias_data  in  BIAS_W  ROM output, 1-cycle read latency.
REQ-014 wr_en  out  1; wr_addr  out  ADDR_W; wr_data  out  8  result RAM write port.
REQ-015 busy  out  1  high from the cycle after accepted start until done; done  out  1  one-cycle pulse; err  out  1  sticky framing error.

Function
REQ-016 FSM states: IDLE, BIAS_REQ, BIAS_CAP, RUN, DONE.
REQ-017 IDLE -> BIAS_REQ on start; start in any other state is ignored.
REQ-018 BIAS_REQ: bias_rd_en=1 and bias_addr=ch for exactly one cycle, then BIAS_CAP.
REQ-019 BIAS_CAP: bias_data is latched into the bias register; next state RUN with pix=0.
REQ-020 RUN: each cycle with in_valid=1 is one beat; cycles with in_valid=0 are ignored, and in_start/in_end are ignored without in_valid.
REQ-021 Beat arithmetic: sum = in_data + sign-extended bias at DATA_W+1 bits; sh = sum >>> FRAC; sh<0 gives 0; sh>127 gives 127; otherwise sh[7:0].
REQ-022 Latency: wr_en=1 with wr_data and wr_addr exactly one cycle after each accepted beat; back-to-back beats give back-to-back writes.
REQ-023 wr_addr = ch*PIX + pix, from a running base register; no multiplier.
REQ-024 The beat with pix==PIX-1 ends the channel; then ch increments and the FSM goes to BIAS_REQ, or to DONE if ch==NUM_CH-1.
REQ-025 Framing: in_start must equal (pix==0) and in_end must equal (pix==PIX-1); any mismatch sets err.
REQ-026 Early in_end (pix<PIX-1): the beat is written, err is set, and the channel terminates as in REQ-024; the next channel base = ch+1 times PIX, so the skipped addresses are left unwritten.
REQ-027 in_valid=1 outside RUN: the beat is dropped, there is no write, and err is set.
REQ-028 DONE: done=1 for one cycle, busy=0 in that cycle, then IDLE; err holds until reset or the next accepted start.
REQ-029 The last write of a layer occurs in the DONE cycle; done and that final wr_en coincide.

Reset
REQ-030 rst_n=1 at a clock edge sets state=IDLE and clears ch, pix, base, bias register, err.
REQ-031 The same reset drives busy, done, wr_en and bias_rd_en to 0, and wr_addr, wr_data and bias_addr to 0.
REQ-032 Reset mid-layer drops any pending write; no wr_en is issued in the cycle following reset.

Verification
REQ-033 NUM_CH=2, PIX=4, bias={16,-16}, start, then 8 well-framed beats of in_data=160.
  - Writes at addr 0..3 with data 11, then addr 4..7 with data 9.
  - done coincides with the addr-7 write; err=0.
REQ-034 Saturation: bias=0, in_data=+4000 gives wr_data=127; in_data=-4000 gives wr_data=0; in_data=2047 gives 127.
REQ-035 Gapped stream: beats separated by 3 idle cycles.
  - Each write lands 1 cycle after its beat.
  - Addresses are contiguous; no extra writes.
REQ-036 Framing errors:
  - in_end on pix=1 in ch0: err=1; ch1 writes start at addr PIX.
  - in_start on pix=2: err=1.
  - A valid beat in IDLE: no write, err=1.
REQ-037 Reset at pix=2 of ch1, then a new start: ch restarts at 0 and the first write is at addr 0; wr_en stays low in the cycle after reset.
REQ-038 start pulsed during RUN: no effect on ch/pix/addresses; the bias ROM sees exactly NUM_CH reads per layer.

Source files
------------

// File: rtl/conv_result_writer_if.sv
// Bus bundle for the convolution result writer: the beat stream, the bias ROM port,
// the result RAM write port and the layer control/status lines.
interface conv_result_writer_if #(
  parameter int DATA_W = 20,
  parameter int BIAS_W = 8,
  parameter int ADDR_W = 15
) ();
  logic                     start;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_start;
  logic                     in_end;
  logic                     bias_rd_en;
  logic [6:0]               bias_addr;
  logic signed [BIAS_W-1:0] bias_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [7:0]               wr_data;
  logic                     busy;
  logic                     done;
  logic                     err;

  // The writer is the slave of the beat stream and the master of the RAM/ROM ports.
  modport slave (
    input  start, in_data, in_valid, in_start, in_end, bias_data,
    output bias_rd_en, bias_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport master (
    output start, in_data, in_valid, in_start, in_end, bias_data,
    input  bias_rd_en, bias_addr, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/conv_result_writer.sv
// Collects multiply-adder result beats for one layer, adds the per-channel bias,
// rescales and clamps to 0..127, and writes them to the result RAM channel by channel.
module conv_result_writer #(
  parameter int DATA_W = 20,
  parameter int BIAS_W = 8,
  parameter int FRAC   = 4,
  parameter int NUM_CH = 6,
  parameter int PIX    = 576,
  parameter int ADDR_W = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_result_writer_if.slave  bus
);

  localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int CH_W  = 7;
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIX - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(PIX);

  typedef enum logic [2:0] {
    IDLE,
    BIAS_REQ,
    BIAS_CAP,
    RUN,
    DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [CH_W-1:0]          ch_reg, ch_next;
  logic [PIX_W-1:0]         pix_reg, pix_next;
  logic [ADDR_W-1:0]        base_reg, base_next;
  logic signed [BIAS_W-1:0] bias_reg, bias_next;
  logic                     err_reg, err_next;
  logic                     wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]        wr_addr_reg, wr_addr_next;
  logic [7:0]               wr_data_reg, wr_data_next;

  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W:0]   sh;
  logic [7:0]               sat;
  logic                     pix_first;
  logic                     pix_last;

  // One extra bit of headroom so that the bias add can never wrap.
  always_comb begin
    sum = {bus.in_data[DATA_W-1], bus.in_data}
        + {{(DATA_W + 1 - BIAS_W){bias_reg[BIAS_W-1]}}, bias_reg};
    sh  = sum >>> FRAC;
    if (sh[DATA_W]) begin
      sat = 8'd0;
    end else if (|sh[DATA_W-1:7]) begin
      sat = 8'd127;
    end else begin
      sat = sh[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      pix_reg     <= '0;
      base_reg    <= '0;
      bias_reg    <= '0;
      err_reg     <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ch_reg      <= ch_next;
      pix_reg     <= pix_next;
      base_reg    <= base_next;
      bias_reg    <= bias_next;
      err_reg     <= err_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ch_next      = ch_reg;
    pix_next     = pix_reg;
    base_next    = base_reg;
    bias_next    = bias_reg;
    err_next     = err_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    pix_first    = (pix_reg == '0);
    pix_last     = (pix_reg == PIX_LAST);

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = BIAS_REQ;
          ch_next    = '0;
          pix_next   = '0;
          base_next  = '0;
          err_next   = 1'b0;
        end
      end
      BIAS_REQ: begin
        state_next = BIAS_CAP;
      end
      BIAS_CAP: begin
        bias_next  = bus.bias_data;
        pix_next   = '0;
        state_next = RUN;
      end
      RUN: begin
        if (bus.in_valid) begin
          wr_en_next   = 1'b1;
          wr_addr_next = base_reg + ADDR_W'(pix_reg);
          wr_data_next = sat;
          if ((bus.in_start != pix_first) || (bus.in_end != pix_last)) begin
            err_next = 1'b1;
          end
          // An early in_end still closes the channel; the next base skips the
          // unwritten tail so every channel keeps its fixed PIX-sized slot.
          if (pix_last || bus.in_end) begin
            pix_next  = '0;
            base_next = base_reg + PIX_STEP;
            if (ch_reg == CH_LAST) begin
              state_next = DONE;
            end else begin
              ch_next    = ch_reg + 1'b1;
              state_next = BIAS_REQ;
            end
          end else begin
            pix_next = pix_reg + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Beats outside RUN are dropped but flagged; this wins over a start-clear.
    if (bus.in_valid && (state_reg != RUN)) begin
      err_next = 1'b1;
    end
  end

  assign bus.bias_rd_en = (state_reg == BIAS_REQ);
  assign bus.bias_addr  = (state_reg == BIAS_REQ) ? ch_reg : '0;
  assign bus.busy       = (state_reg == BIAS_REQ) || (state_reg == BIAS_CAP) || (state_reg == RUN);
  assign bus.done       = (state_reg == DONE);
  assign bus.err        = err_reg;
  assign bus.wr_en      = wr_en_reg;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer with a 2-channel, 4-pixel layer and a
// small bias ROM model with one cycle of read latency.
module tb_conv_result_writer;
  localparam int DATA_W = 20;
  localparam int BIAS_W = 8;
  localparam int FRAC   = 4;
  localparam int NUM_CH = 2;
  localparam int PIX    = 4;
  localparam int ADDR_W = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_result_writer_if #(.DATA_W(DATA_W), .BIAS_W(BIAS_W), .ADDR_W(ADDR_W)) bus ();

  conv_result_writer #(
    .DATA_W(DATA_W), .BIAS_W(BIAS_W), .FRAC(FRAC),
    .NUM_CH(NUM_CH), .PIX(PIX), .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic signed [BIAS_W-1:0] rom [0:1];
  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int rd_count = 0;

  int sat_in  [8] = '{4000, -4000, 2047, 100, 15, 16, -16, 2048};
  int sat_exp [8] = '{127, 0, 127, 6, 0, 1, 0, 127};
  int gap_exp [8] = '{1, 3, 5, 7, 0, 1, 3, 5};

  always @(posedge clk) begin
    if (bus.bias_rd_en) bus.bias_data <= rom[bus.bias_addr[0]];
  end

  always @(negedge clk) begin
    if (bus.wr_en) wr_count <= wr_count + 1;
    if (bus.bias_rd_en) rd_count <= rd_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_beat(input int d, input bit s, input bit e);
    bus.in_data  = DATA_W'(d);
    bus.in_valid = 1'b1;
    bus.in_start = s;
    bus.in_end   = e;
    tick();
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_end   = 1'b0;
  endtask

  task automatic start_layer();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    idle(2);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle(2);
    vectors++;
    if ({bus.busy, bus.done, bus.wr_en, bus.bias_rd_en, bus.err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/done/wr_en/rd_en/err=%b, want 00000",
               {bus.busy, bus.done, bus.wr_en, bus.bias_rd_en, bus.err});
    end
    vectors++;
    if (bus.wr_addr !== '0 || bus.wr_data !== 8'd0 || bus.bias_addr !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_buses: got wr_addr=%0d wr_data=%0d bias_addr=%0d, want 0 0 0",
               bus.wr_addr, bus.wr_data, bus.bias_addr);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got wr_en=%b busy=%b, want 0 0", bus.wr_en, bus.busy);
    end
    $display("reset: checked");
  endtask

  task automatic test_basic();
    int rd0, wr0, a, x;
    rom[0] = 8'sd16;
    rom[1] = -8'sd16;
    rd0 = rd_count;
    wr0 = wr_count;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.bias_rd_en !== 1'b1 || bus.bias_addr !== 7'd0) begin
      miscompares++;
      $display("FAIL basic_bias_req: got busy=%b rd_en=%b addr=%0d, want 1 1 0",
               bus.busy, bus.bias_rd_en, bus.bias_addr);
    end
    idle(2);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int p = 0; p < PIX; p++) begin
        drive_beat(160, p == 0, p == PIX - 1);
        a = c * PIX + p;
        x = (c == 0) ? 11 : 9;
        vectors++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(a) || bus.wr_data !== 8'(x)
            || bus.done !== ((c == 1) && (p == 3))) begin
          miscompares++;
          $display("FAIL basic_write ch%0d p%0d: got en=%b addr=%0d data=%0d done=%b, want en=1 addr=%0d data=%0d done=%b",
                   c, p, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, a, x, (c == 1) && (p == 3));
        end
        $display("basic: write addr=%0d data=%0d", bus.wr_addr, bus.wr_data);
      end
      if (c == 0) idle(2);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_cycle: got busy=%b err=%b, want 0 0", bus.busy, bus.err);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after_done: got done=%b wr_en=%b, want 0 0", bus.done, bus.wr_en);
    end
    vectors++;
    if (rd_count - rd0 !== 2 || wr_count - wr0 !== 8) begin
      miscompares++;
      $display("FAIL basic_counts: got rom_reads=%0d writes=%0d, want 2 8",
               rd_count - rd0, wr_count - wr0);
    end
  endtask

  task automatic test_saturation();
    rom[0] = 8'sd0;
    rom[1] = 8'sd0;
    start_layer();
    for (int i = 0; i < 8; i++) begin
      if (i == PIX) idle(2);
      drive_beat(sat_in[i], (i % PIX) == 0, (i % PIX) == PIX - 1);
      vectors++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(i) || bus.wr_data !== 8'(sat_exp[i])) begin
        miscompares++;
        $display("FAIL sat_write in=%0d: got en=%b addr=%0d data=%0d, want en=1 addr=%0d data=%0d",
                 sat_in[i], bus.wr_en, bus.wr_addr, bus.wr_data, i, sat_exp[i]);
      end
      $display("saturation: in=%0d -> data=%0d", sat_in[i], bus.wr_data);
    end
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_err: got err=%b, want 0", bus.err);
    end
    tick();
  endtask

  task automatic test_gapped();
    int wr0;
    rom[0] = 8'sd16;
    rom[1] = -8'sd16;
    wr0 = wr_count;
    start_layer();
    for (int i = 0; i < 8; i++) begin
      drive_beat(32 * (i % PIX), (i % PIX) == 0, (i % PIX) == PIX - 1);
      vectors++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(i) || bus.wr_data !== 8'(gap_exp[i])) begin
        miscompares++;
        $display("FAIL gap_write %0d: got en=%b addr=%0d data=%0d, want en=1 addr=%0d data=%0d",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, i, gap_exp[i]);
      end
      $display("gapped: write addr=%0d data=%0d", bus.wr_addr, bus.wr_data);
      for (int g = 0; g < 3; g++) begin
        tick();
        vectors++;
        if (bus.wr_en !== 1'b0) begin
          miscompares++;
          $display("FAIL gap_idle beat%0d gap%0d: got wr_en=%b, want 0", i, g, bus.wr_en);
        end
      end
    end
    vectors++;
    if (wr_count - wr0 !== 8) begin
      miscompares++;
      $display("FAIL gap_count: got writes=%0d, want 8", wr_count - wr0);
    end
  endtask

  task automatic test_framing();
    int wr0;
    rom[0] = 8'sd16;
    rom[1] = -8'sd16;
    wr0 = wr_count;
    start_layer();
    drive_beat(160, 1'b1, 1'b0);
    drive_beat(160, 1'b0, 1'b1);
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(1) || bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_early_end: got en=%b addr=%0d err=%b, want 1 1 1",
               bus.wr_en, bus.wr_addr, bus.err);
    end
    idle(2);
    for (int p = 0; p < PIX; p++) begin
      drive_beat(160, p == 0, p == PIX - 1);
      vectors++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(PIX + p) || bus.wr_data !== 8'd9) begin
        miscompares++;
        $display("FAIL frame_ch1_addr p%0d: got en=%b addr=%0d data=%0d, want 1 %0d 9",
                 p, bus.wr_en, bus.wr_addr, bus.wr_data, PIX + p);
      end
      $display("framing: ch1 write addr=%0d", bus.wr_addr);
    end
    tick();
    vectors++;
    if (bus.err !== 1'b1 || wr_count - wr0 !== 6) begin
      miscompares++;
      $display("FAIL frame_sticky: got err=%b writes=%0d, want 1 6", bus.err, wr_count - wr0);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_start_clear: got err=%b, want 0", bus.err);
    end
    idle(2);
    drive_beat(160, 1'b1, 1'b0);
    drive_beat(160, 1'b0, 1'b0);
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_clean_beats: got err=%b, want 0", bus.err);
    end
    drive_beat(160, 1'b1, 1'b0);
    vectors++;
    if (bus.err !== 1'b1 || bus.wr_addr !== ADDR_W'(2)) begin
      miscompares++;
      $display("FAIL frame_late_start: got err=%b addr=%0d, want 1 2", bus.err, bus.wr_addr);
    end
    drive_beat(160, 1'b0, 1'b1);
    idle(2);
    for (int p = 0; p < PIX; p++) drive_beat(160, p == 0, p == PIX - 1);
    tick();
    pulse_reset();
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_reset_clear: got err=%b, want 0", bus.err);
    end
    drive_beat(160, 1'b1, 1'b0);
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_idle_beat: got wr_en=%b err=%b, want 0 1", bus.wr_en, bus.err);
    end
    $display("framing: idle beat err=%b", bus.err);
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    rom[0] = 8'sd16;
    rom[1] = -8'sd16;
    start_layer();
    for (int p = 0; p < PIX; p++) drive_beat(160, p == 0, p == PIX - 1);
    idle(2);
    drive_beat(160, 1'b1, 1'b0);
    drive_beat(160, 1'b0, 1'b0);
    bus.in_data  = DATA_W'(160);
    bus.in_valid = 1'b1;
    rst_n        = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got wr_en=%b busy=%b err=%b, want 0 0 0",
               bus.wr_en, bus.busy, bus.err);
    end
    tick();
    vectors++;
    if (bus.wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_write: got wr_en=%b, want 0", bus.wr_en);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.bias_rd_en !== 1'b1 || bus.bias_addr !== 7'd0) begin
      miscompares++;
      $display("FAIL midreset_ch0: got rd_en=%b bias_addr=%0d, want 1 0", bus.bias_rd_en, bus.bias_addr);
    end
    idle(2);
    drive_beat(160, 1'b1, 1'b0);
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== '0 || bus.wr_data !== 8'd11) begin
      miscompares++;
      $display("FAIL midreset_first_write: got en=%b addr=%0d data=%0d, want 1 0 11",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    $display("reset_mid: restart write addr=%0d data=%0d", bus.wr_addr, bus.wr_data);
    for (int p = 1; p < PIX; p++) drive_beat(160, 1'b0, p == PIX - 1);
    idle(2);
    for (int p = 0; p < PIX; p++) drive_beat(160, p == 0, p == PIX - 1);
    tick();
  endtask

  task automatic test_start_in_run();
    int rd0, wr0;
    rom[0] = 8'sd16;
    rom[1] = -8'sd16;
    rd0 = rd_count;
    wr0 = wr_count;
    start_layer();
    drive_beat(160, 1'b1, 1'b0);
    bus.start = 1'b1;
    drive_beat(160, 1'b0, 1'b0);
    vectors++;
    if (bus.wr_addr !== ADDR_W'(1) || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL run_start_beat: got addr=%0d busy=%b, want 1 1", bus.wr_addr, bus.busy);
    end
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL run_start_idle: got wr_en=%b, want 0", bus.wr_en);
    end
    drive_beat(160, 1'b0, 1'b0);
    drive_beat(160, 1'b0, 1'b1);
    vectors++;
    if (bus.wr_addr !== ADDR_W'(3) || bus.bias_rd_en !== 1'b1 || bus.bias_addr !== 7'd1) begin
      miscompares++;
      $display("FAIL run_start_ch_end: got addr=%0d rd_en=%b bias_addr=%0d, want 3 1 1",
               bus.wr_addr, bus.bias_rd_en, bus.bias_addr);
    end
    bus.start = 1'b1;
    idle(2);
    bus.start = 1'b0;
    for (int p = 0; p < PIX; p++) begin
      drive_beat(160, p == 0, p == PIX - 1);
      vectors++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(PIX + p) || bus.wr_data !== 8'd9) begin
        miscompares++;
        $display("FAIL run_start_ch1 p%0d: got en=%b addr=%0d data=%0d, want 1 %0d 9",
                 p, bus.wr_en, bus.wr_addr, bus.wr_data, PIX + p);
      end
      $display("start_in_run: write addr=%0d data=%0d", bus.wr_addr, bus.wr_data);
    end
    tick();
    vectors++;
    if (rd_count - rd0 !== NUM_CH || wr_count - wr0 !== 8 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL run_start_counts: got rom_reads=%0d writes=%0d err=%b, want %0d 8 0",
               rd_count - rd0, wr_count - wr0, bus.err, NUM_CH);
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_end   = 1'b0;
    rom[0]       = 8'sd0;
    rom[1]       = 8'sd0;
    test_reset();
    test_basic();
    test_saturation();
    test_gapped();
    test_framing();
    test_reset_mid();
    test_start_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
